hilo_divider: RTL

HILO_DIVIDER -- requirements
Module: hilo_divider

---
 rtl/hilo_divider.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hilo_divider.sv
// hilo_divider: HI/LO register pair with a 32-cycle restoring divider (DIV/DIVU) and mthi/mtlo writes.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_op_x,
    input  logic [WIDTH-1:0] div_op_y,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_busy,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, ym_q, ym_d, quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
    logic             busy_q, busy_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] xm, ymag, q_next, r_next;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        xm      = (div_signed && div_op_x[WIDTH-1]) ? -div_op_x : div_op_x;
        ymag    = (div_signed && div_op_y[WIDTH-1]) ? -div_op_y : div_op_y;
        // quo_q starts as the dividend magnitude; its MSB shifts into the remainder each step
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, ym_q};
        r_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        ym_d    = ym_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        dbz_d   = 1'b0;
        if (state_q == IDLE) begin
            if (div_start) begin
                state_d = BUSY;
                busy_d  = 1'b1;
                cnt_d   = '0;
                x_d     = div_op_x;
                ym_d    = ymag;
                quo_d   = xm;
                rem_d   = '0;
                qneg_d  = div_signed && (div_op_x[WIDTH-1] ^ div_op_y[WIDTH-1]);
                rneg_d  = div_signed && div_op_x[WIDTH-1];
                zero_d  = (div_op_y == '0);
            end else begin
                hi_d = mthi ? wr_data : hi_q;
                lo_d = mtlo ? wr_data : lo_q;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            quo_d = q_next;
            rem_d = r_next;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                dbz_d   = zero_q;
                lo_d    = zero_q ? '1 : (qneg_q ? -q_next : q_next);
                hi_d    = zero_q ? x_q : (rneg_q ? -r_next : r_next);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            ym_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            ym_q    <= ym_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            dbz_q   <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_busy    = busy_q;
    assign div_by_zero = dbz_q;
endmodule
